arb_token_ctrl: RTL and testbench

ARB_TOKEN_CTRL -- requirements
Module: arb_token_ctrl

---
 rtl/arb_pkg.sv | 28 ++
 rtl/arb_onehot2idx.sv | 30 +++
 rtl/arb_token_ctrl.sv | 135 +++++++++++++
 tb/tb_arb_token_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
//==============================================================================
// Module      : arb_pkg
// Description : Shared FSM state encoding, default sizing constants and the
//               index-width helper for the arbiter token controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package arb_pkg;

    localparam int c_N_DEFAULT   = 8;
    localparam int c_TMO_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_BUSY = 2'd2,
        ST_ROT  = 2'd3
    } arb_state_t;

    // Binary index width for an n-wide one-hot vector (never narrower than 1).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_onehot2idx.sv
//==============================================================================
// Module      : arb_onehot2idx
// Description : One-hot to binary index encoder; an all-zero input yields 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module arb_onehot2idx
    import arb_pkg::*;
#(
    parameter int N = c_N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_idx
);

    // OR-reduction of set-bit indices: exact for one-hot, zero for no bits.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arb_token_ctrl.sv
//==============================================================================
// Module      : arb_token_ctrl
// Description : Token controller for a priority arbiter: acknowledges a
//               request, latches the grant holder, holds the shared resource
//               until completion, then rotates the priority token.
//               Optional BUSY timeout enabled by macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module arb_token_ctrl
    import arb_pkg::*;
#(
    parameter int N   = c_N_DEFAULT,
    parameter int TMO = c_TMO_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arb_req,
    input  logic [N-1:0]            arb_gnt,
    output logic                    arb_ack,
    output logic [N-1:0]            prio,
    output logic                    res_req,
    input  logic                    res_done,
    output logic [idx_width(N)-1:0] owner,
    output logic                    busy,
    output logic                    tmo_err
);

    if (N < 2 || TMO < 1) begin : g_param_check
        $error("arb_token_ctrl: N must be >= 2 and TMO >= 1");
    end

    arb_state_t     r_state;
    logic [N-1:0]   r_owner_q;
    logic [N-1:0]   r_prio;
    logic           r_arb_ack;
    logic           r_res_req;
    logic           r_busy;
    logic           r_tmo_err;
    logic           w_tmo_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TMO + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Cleared while in ACK so every BUSY entry starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ACK) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_BUSY) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == ST_BUSY) && (r_tmo_cnt == c_TMO_W'(TMO - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner_q <= '0;
            r_prio    <= N'(1);
            r_arb_ack <= 1'b0;
            r_res_req <= 1'b0;
            r_busy    <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_arb_ack <= 1'b0;
            r_tmo_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arb_req) begin
                        r_state   <= ST_ACK;
                        r_arb_ack <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (|arb_gnt) begin
                        r_state   <= ST_BUSY;
                        r_owner_q <= arb_gnt;
                        r_res_req <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (res_done) begin
                        r_state   <= ST_ROT;
                        r_res_req <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_state   <= ST_ROT;
                        r_res_req <= 1'b0;
                        r_tmo_err <= 1'b1;
                    end
                end
                ST_ROT: begin
                    r_prio  <= {r_owner_q[N-2:0], r_owner_q[N-1]};
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_res_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    arb_onehot2idx #(
        .N (N),
        .W (idx_width(N))
    ) u_owner_enc (
        .i_onehot (r_owner_q),
        .o_idx    (owner)
    );

    assign arb_ack = r_arb_ack;
    assign prio    = r_prio;
    assign res_req = r_res_req;
    assign busy    = r_busy;
    assign tmo_err = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_arb_token_ctrl.sv
//==============================================================================
// Module      : tb_arb_token_ctrl
// Description : Directed self-checking bench for arb_token_ctrl (N=8, TMO=16).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_arb_token_ctrl;

    logic       clk;
    logic       rst;
    logic       arb_req;
    logic [7:0] arb_gnt;
    logic       arb_ack;
    logic [7:0] prio;
    logic       res_req;
    logic       res_done;
    logic [2:0] owner;
    logic       busy;
    logic       tmo_err;

    int n_tests;
    int n_fail;

    arb_token_ctrl #(
        .N   (8),
        .TMO (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arb_req  (arb_req),
        .arb_gnt  (arb_gnt),
        .arb_ack  (arb_ack),
        .prio     (prio),
        .res_req  (res_req),
        .res_done (res_done),
        .owner    (owner),
        .busy     (busy),
        .tmo_err  (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if (prio !== 8'h01 || busy !== 1'b0 || res_req !== 1'b0 || arb_ack !== 1'b0) begin
            $display("FAIL reset_init: prio=%h busy=%b res_req=%b ack=%b, need 01/0/0/0",
                     prio, busy, res_req, arb_ack);
            n_fail++;
        end
        n_tests++;
        if (owner !== 3'd0 || tmo_err !== 1'b0) begin
            $display("FAIL reset_init_owner: owner=%0d tmo_err=%b, need 0/0", owner, tmo_err);
            n_fail++;
        end
        rst = 1'b0;
        arb_req = 1'b1;
        step();
        arb_gnt = 8'h20;
        arb_req = 1'b0;
        step();
        arb_gnt = 8'h00;
        n_tests++;
        if (res_req !== 1'b1 || owner !== 3'd5) begin
            $display("FAIL reset_busy_entry: res_req=%b owner=%0d, need 1/5", res_req, owner);
            n_fail++;
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (prio !== 8'h01 || res_req !== 1'b0 || busy !== 1'b0 || owner !== 3'd0) begin
            $display("FAIL reset_async: prio=%h res_req=%b busy=%b owner=%0d, need 01/0/0/0",
                     prio, res_req, busy, owner);
            n_fail++;
        end
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0 || arb_ack !== 1'b0 || prio !== 8'h01) begin
            $display("FAIL reset_release: busy=%b ack=%b prio=%h, need 0/0/01", busy, arb_ack, prio);
            n_fail++;
        end
    endtask

    task automatic test_normal_grant();
        arb_req = 1'b1;
        step();
        n_tests++;
        if (arb_ack !== 1'b1 || busy !== 1'b1 || res_req !== 1'b0) begin
            $display("FAIL grant_ack: ack=%b busy=%b res_req=%b, need 1/1/0", arb_ack, busy, res_req);
            n_fail++;
        end
        arb_gnt = 8'h04;
        arb_req = 1'b0;
        step();
        arb_gnt = 8'h00;
        n_tests++;
        if (arb_ack !== 1'b0 || res_req !== 1'b1 || owner !== 3'd2) begin
            $display("FAIL grant_busy1: ack=%b res_req=%b owner=%0d, need 0/1/2", arb_ack, res_req, owner);
            n_fail++;
        end
        step();
        n_tests++;
        if (res_req !== 1'b1) begin
            $display("FAIL grant_busy2: res_req=%b, need 1", res_req);
            n_fail++;
        end
        step();
        n_tests++;
        if (res_req !== 1'b1) begin
            $display("FAIL grant_busy3: res_req=%b, need 1", res_req);
            n_fail++;
        end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        n_tests++;
        if (res_req !== 1'b0 || busy !== 1'b1 || prio !== 8'h01) begin
            $display("FAIL grant_rot: res_req=%b busy=%b prio=%h, need 0/1/01", res_req, busy, prio);
            n_fail++;
        end
        step();
        n_tests++;
        if (prio !== 8'h08 || busy !== 1'b0 || owner !== 3'd2) begin
            $display("FAIL grant_prio: prio=%h busy=%b owner=%0d, need 08/0/2", prio, busy, owner);
            n_fail++;
        end
    endtask

    task automatic test_withdraw();
        arb_req = 1'b1;
        step();
        arb_req = 1'b0;
        arb_gnt = 8'h00;
        n_tests++;
        if (arb_ack !== 1'b1) begin
            $display("FAIL withdraw_ack: ack=%b, need 1", arb_ack);
            n_fail++;
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || res_req !== 1'b0 || prio !== 8'h08) begin
            $display("FAIL withdraw_idle: busy=%b res_req=%b prio=%h, need 0/0/08", busy, res_req, prio);
            n_fail++;
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || res_req !== 1'b0 || arb_ack !== 1'b0) begin
            $display("FAIL withdraw_stay: busy=%b res_req=%b ack=%b, need 0/0/0", busy, res_req, arb_ack);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        arb_req = 1'b1;
        step();
        arb_req = 1'b0;
        arb_gnt = 8'h80;
        step();
        arb_gnt = 8'h00;
        n_tests++;
        if (owner !== 3'd7 || res_req !== 1'b1) begin
            $display("FAIL wrap_owner: owner=%0d res_req=%b, need 7/1", owner, res_req);
            n_fail++;
        end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        step();
        n_tests++;
        if (prio !== 8'h01 || busy !== 1'b0) begin
            $display("FAIL wrap_prio: prio=%h busy=%b, need 01/0", prio, busy);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int n_ack;
        int first_ack;
        int second_ack;
        n_ack = 0;
        first_ack = 0;
        second_ack = 0;
        arb_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (arb_ack === 1'b1) begin
                n_ack++;
                if (n_ack == 1) first_ack = c;
                if (n_ack == 2) second_ack = c;
            end
            arb_gnt  = (arb_ack === 1'b1) ? 8'h02 : 8'h00;
            res_done = (res_req === 1'b1);
            if (c >= 7) arb_req = 1'b0;
        end
        res_done = 1'b0;
        arb_gnt = 8'h00;
        n_tests++;
        if (n_ack !== 2 || first_ack !== 1) begin
            $display("FAIL b2b_acks: count=%0d first=%0d, need 2/1", n_ack, first_ack);
            n_fail++;
        end
        n_tests++;
        if (second_ack - first_ack !== 4) begin
            $display("FAIL b2b_spacing: gap=%0d, need 4", second_ack - first_ack);
            n_fail++;
        end
        step();
        n_tests++;
        if (prio !== 8'h04 || busy !== 1'b0) begin
            $display("FAIL b2b_prio: prio=%h busy=%b, need 04/0", prio, busy);
            n_fail++;
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout(input logic done_at_limit, input logic [7:0] gnt,
                                input logic [7:0] exp_prio, input int exp_err);
        int busy_cyc;
        int tmo_seen;
        int tmo_at;
        busy_cyc = 0;
        tmo_seen = 0;
        tmo_at = 0;
        arb_req = 1'b1;
        step();
        arb_req = 1'b0;
        arb_gnt = gnt;
        step();
        arb_gnt = 8'h00;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            if (res_req === 1'b1) busy_cyc++;
            if (tmo_err === 1'b1) begin
                tmo_seen++;
                tmo_at = busy_cyc;
            end
            res_done = done_at_limit && (res_req === 1'b1) && (busy_cyc == 16);
            step();
        end
        res_done = 1'b0;
        n_tests++;
        if (busy_cyc !== 16 || busy !== 1'b0) begin
            $display("FAIL tmo_busy_len: busy_cycles=%0d busy=%b, need 16/0", busy_cyc, busy);
            n_fail++;
        end
        n_tests++;
        if (tmo_seen !== exp_err || (exp_err == 1 && tmo_at !== 16)) begin
            $display("FAIL tmo_pulse: pulses=%0d at=%0d, need %0d at 16", tmo_seen, tmo_at, exp_err);
            n_fail++;
        end
        n_tests++;
        if (prio !== exp_prio) begin
            $display("FAIL tmo_prio: prio=%h, need %h", prio, exp_prio);
            n_fail++;
        end
    endtask
`else
    task automatic test_no_timeout();
        int tmo_seen;
        tmo_seen = 0;
        arb_req = 1'b1;
        step();
        arb_req = 1'b0;
        arb_gnt = 8'h10;
        step();
        arb_gnt = 8'h00;
        for (int i = 0; i < 24; i++) begin
            if (tmo_err === 1'b1) tmo_seen++;
            step();
        end
        n_tests++;
        if (res_req !== 1'b1 || busy !== 1'b1 || tmo_seen !== 0) begin
            $display("FAIL notmo_hold: res_req=%b busy=%b tmo_pulses=%0d, need 1/1/0",
                     res_req, busy, tmo_seen);
            n_fail++;
        end
        res_done = 1'b1;
        step();
        res_done = 1'b0;
        step();
        n_tests++;
        if (prio !== 8'h20 || busy !== 1'b0 || tmo_err !== 1'b0) begin
            $display("FAIL notmo_prio: prio=%h busy=%b tmo_err=%b, need 20/0/0", prio, busy, tmo_err);
            n_fail++;
        end
    endtask
`endif

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        arb_req  = 1'b0;
        arb_gnt  = 8'h00;
        res_done = 1'b0;
        step();
        step();
        test_reset();
        test_normal_grant();
        test_withdraw();
        test_wrap();
        test_back_to_back();
`ifdef ARB_TIMEOUT_EN
        test_timeout(1'b0, 8'h10, 8'h20, 1);
        test_timeout(1'b1, 8'h01, 8'h02, 0);
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
